seg7_scan_counter: RTL and testbench
====================================

# seg7_scan_counter

Parametrised multi-digit successor to the single-digit seven-segment seconds counter. Holds a DIGITS-wide BCD (or hex) up/down counter advanced by an internal prescaler and drives a time-multiplexed common display: one-hot digit select plus registered segment pattern. Sits directly behind the top-level `uo_out`/`uio_out` pins, with controls taken from `ui_in`.

## Interface
- DIGITS, 4: number of digits, 1..8
- TICK_DIV, 10_000_000: clk cycles per count step, ≥2
- SCAN_DIV, 1024: clk cycles each digit is shown, ≥2
- HEX, 0: 0 = decimal digits 0..9, 1 = hex digits 0..F

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  design enable; low freezes all state and blanks outputs
- up_dn  in  1  1 = count up, 0 = count down
- pause  in  1  freezes prescaler and count; scan continues
- clear  in  1  synchronous clear of count and prescaler
- blank_lz  in  1  leading-zero blanking enable
- segments  out  7  segment pattern, bit0 = a … bit6 = g, active high
- dp  out  1  decimal point, active high
- digit_sel  out  DIGITS  one-hot digit enable, bit0 = least-significant digit
- count  out  4*DIGITS  current count, 4 bits per digit
- wrap  out  1  one-cycle pulse on counter wrap

## Operation
- Reset: prescaler 0, count 0, scan index 0, scan timer 0; segments, dp, digit_sel, wrap all 0.
- Prescaler: counts 0..TICK_DIV-1 when ena=1, pause=0; a step occurs on the edge where it wraps from TICK_DIV-1.
- Step up: digit 0 increments; any digit at 9 (HEX: F) rolls to 0 with carry. All digits at max → all 0, wrap asserted.
- Step down: digit 0 decrements; any digit at 0 rolls to 9 (HEX: F) with borrow. All 0 → all max, wrap asserted.
- up_dn is sampled only at the step edge; a mid-interval change takes effect on the next step.
- clear=1: count and prescaler → 0 on the next edge; overrides a coincident step; wrap not asserted; scan unaffected.
- pause=1: prescaler and count hold; scan and display continue.
- Scan: scan timer counts 0..SCAN_DIV-1; on wrap, index advances 0→1→…→DIGITS-1→0.
- Display registers, every edge with ena=1: digit_sel ← onehot(index); segments ← decode(digit[index]); dp ← pause and index==0.
- Decode: 0=0x3F 1=0x06 2=0x5B 3=0x4F 4=0x66 5=0x6D 6=0x7D 7=0x07 8=0x7F 9=0x6F A=0x77 b=0x7C C=0x39 d=0x5E E=0x79 F=0x71. In decimal mode, values >9 are unreachable.
- Leading-zero blanking: with blank_lz=1, digit i>0 shows segments 0x00 when it and every higher digit are 0. Digit 0 is never blanked.
- ena=0: all counters hold; next edge drives digit_sel, segments, dp, wrap to 0.

## Timing
- count changes on the prescaler-wrap edge; wrap is high for exactly the cycle in which count first shows the wrapped value.
- Display latency: digit_sel/segments reflect index and count one cycle after they change. Each digit is held for exactly SCAN_DIV cycles.
- First valid digit_sel (0…01) appears on the first edge after rst_n deasserts with ena=1.
- Reset asserted mid-operation clears all state immediately, with no clk edge needed.
- Widths: prescaler $clog2(TICK_DIV), scan timer $clog2(SCAN_DIV), index $clog2(DIGITS) (min 1).

## Structure
- seg7_pkg: segment encoding constants (0x00..0x71 above), segment bit-order definitions, and the `digit_t` (4-bit) typedef.
- Sub-module seg7_decode: combinational digit→segments with a blank input, instantiated once on the muxed digit.

## Test plan
DIGITS=4, TICK_DIV=4, SCAN_DIV=2 unless noted.
- Reset, ena=1, up_dn=1, 40 cycles → count=0x0010; wrap never high.
- From 0, up_dn=0, one step → count=0x9999, wrap high for 1 cycle. With HEX=1, same step → 0xFFFF.
- DIGITS=2, up, 100 steps → count 0x99→0x00 with a single wrap pulse.
- count=0x0010, blank_lz=0 → digit_sel sequence 0001,0010,0100,1000, each held 2 cycles, with segments 0x3F,0x06,0x3F,0x3F. With blank_lz=1 → 0x3F,0x06,0x00,0x00. At count=0, only digit0 shows 0x3F.
- clear coincident with a step → count=0x0000, no wrap. pause=1 → count holds for 20 cycles, dp=1 only while digit_sel=0001.
- rst_n pulsed low mid-count → all outputs 0 with no clk edge; count restarts from 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan counter.
//   digit_t    : one 4-bit BCD/hex digit
//   seg_t      : segment pattern, bit SegA (0) = a ... bit SegG (6) = g, active high
//   seg_encode : digit -> segment pattern (0..9, A, b, C, d, E, F)
package seg7_pkg;

  typedef logic [3:0] digit_t;

  localparam int unsigned SegWidth = 7;
  typedef logic [SegWidth-1:0] seg_t;

  // Segment bit positions within seg_t.
  localparam int unsigned SegA = 0;
  localparam int unsigned SegB = 1;
  localparam int unsigned SegC = 2;
  localparam int unsigned SegD = 3;
  localparam int unsigned SegE = 4;
  localparam int unsigned SegF = 5;
  localparam int unsigned SegG = 6;

  localparam seg_t SegBlank = 7'h00;
  localparam seg_t SegDig0  = 7'h3F;
  localparam seg_t SegDig1  = 7'h06;
  localparam seg_t SegDig2  = 7'h5B;
  localparam seg_t SegDig3  = 7'h4F;
  localparam seg_t SegDig4  = 7'h66;
  localparam seg_t SegDig5  = 7'h6D;
  localparam seg_t SegDig6  = 7'h7D;
  localparam seg_t SegDig7  = 7'h07;
  localparam seg_t SegDig8  = 7'h7F;
  localparam seg_t SegDig9  = 7'h6F;
  localparam seg_t SegDigA  = 7'h77;
  localparam seg_t SegDigB  = 7'h7C;
  localparam seg_t SegDigC  = 7'h39;
  localparam seg_t SegDigD  = 7'h5E;
  localparam seg_t SegDigE  = 7'h79;
  localparam seg_t SegDigF  = 7'h71;

  function automatic seg_t seg_encode(digit_t d);
    seg_t s;
    case (d)
      4'h0:    s = SegDig0;
      4'h1:    s = SegDig1;
      4'h2:    s = SegDig2;
      4'h3:    s = SegDig3;
      4'h4:    s = SegDig4;
      4'h5:    s = SegDig5;
      4'h6:    s = SegDig6;
      4'h7:    s = SegDig7;
      4'h8:    s = SegDig8;
      4'h9:    s = SegDig9;
      4'hA:    s = SegDigA;
      4'hB:    s = SegDigB;
      4'hC:    s = SegDigC;
      4'hD:    s = SegDigD;
      4'hE:    s = SegDigE;
      default: s = SegDigF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_counter_if.sv
// Control/display bundle of the scan counter.
//   master : drives ena, up_dn, pause, clear, blank_lz; observes the display and count
//   slave  : the counter itself
interface seg7_scan_counter_if #(
  parameter int unsigned DIGITS = 4
) ();
  import seg7_pkg::*;

  logic                  ena;
  logic                  up_dn;
  logic                  pause;
  logic                  clear;
  logic                  blank_lz;
  seg_t                  segments;
  logic                  dp;
  logic [DIGITS-1:0]     digit_sel;
  logic [4*DIGITS-1:0]   count;
  logic                  wrap;

  modport master (
    output ena, up_dn, pause, clear, blank_lz,
    input  segments, dp, digit_sel, count, wrap
  );

  modport slave (
    input  ena, up_dn, pause, clear, blank_lz,
    output segments, dp, digit_sel, count, wrap
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational digit -> segment decoder.
//   digit_i : digit value to show
//   blank_i : force all segments off
//   seg_o   : segment pattern, active high
module seg7_decode
  import seg7_pkg::*;
(
  input  digit_t digit_i,
  input  logic   blank_i,
  output seg_t   seg_o
);

  always_comb begin
    seg_o = blank_i ? SegBlank : seg_encode(digit_i);
  end

endmodule

// File: rtl/seg7_scan_counter.sv
// Multi-digit BCD/hex up/down counter with a time-multiplexed seven-segment display.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of seg7_scan_counter_if (controls in; segments, dp, digit_sel,
//           count, wrap out). Display outputs are registered.
module seg7_scan_counter
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 10_000_000,
  parameter int unsigned SCAN_DIV = 1024,
  parameter int unsigned HEX      = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_counter_if.slave bus
);

  localparam int unsigned PreW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PreW-1:0]  PreMax   = PreW'(TICK_DIV - 1);
  localparam logic [ScanW-1:0] ScanMax  = ScanW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0]  IdxMax   = IdxW'(DIGITS - 1);
  localparam digit_t           DigitMax = (HEX != 0) ? 4'hF : 4'h9;

  logic [PreW-1:0]         presc_q, presc_d;
  digit_t [DIGITS-1:0]     cnt_q, cnt_d, cnt_step;
  logic [ScanW-1:0]        scan_q, scan_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [DIGITS-1:0]       sel_q, sel_d;
  seg_t                    seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    wrap_q, wrap_d;

  logic                    tick;
  logic                    carry;
  digit_t                  cur_digit;
  logic                    cur_blank;
  seg_t                    cur_seg;

  assign tick = bus.ena && !bus.pause && (presc_q == PreMax);

  // Ripple increment/decrement; carry surviving past the top digit means every digit rolled
  // over, i.e. the whole counter wrapped.
  always_comb begin
    cnt_step = cnt_q;
    carry    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (bus.up_dn) begin
          if (cnt_q[i] == DigitMax) begin
            cnt_step[i] = '0;
          end else begin
            cnt_step[i] = cnt_q[i] + 4'd1;
            carry       = 1'b0;
          end
        end else begin
          if (cnt_q[i] == '0) begin
            cnt_step[i] = DigitMax;
          end else begin
            cnt_step[i] = cnt_q[i] - 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
  end

  // Digit under the scan pointer, and whether it is a leading zero (itself and all higher
  // digits zero). Digit 0 is never blanked.
  always_comb begin
    cur_digit = '0;
    cur_blank = bus.blank_lz && (idx_q != '0);
    for (int i = 0; i < DIGITS; i++) begin
      if (IdxW'(i) == idx_q) begin
        cur_digit = cnt_q[i];
      end
      if ((IdxW'(i) >= idx_q) && (cnt_q[i] != '0)) begin
        cur_blank = 1'b0;
      end
    end
  end

  seg7_decode u_decode (
    .digit_i (cur_digit),
    .blank_i (cur_blank),
    .seg_o   (cur_seg)
  );

  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    scan_d  = scan_q;
    idx_d   = idx_q;
    sel_d   = '0;
    seg_d   = SegBlank;
    dp_d    = 1'b0;
    wrap_d  = 1'b0;

    if (bus.ena) begin
      // Clear beats a coincident step and suppresses its wrap.
      if (bus.clear) begin
        presc_d = '0;
        cnt_d   = '0;
      end else if (!bus.pause) begin
        if (tick) begin
          presc_d = '0;
          cnt_d   = cnt_step;
          wrap_d  = carry;
        end else begin
          presc_d = presc_q + PreW'(1);
        end
      end

      if (scan_q == ScanMax) begin
        scan_d = '0;
        idx_d  = (idx_q == IdxMax) ? '0 : idx_q + IdxW'(1);
      end else begin
        scan_d = scan_q + ScanW'(1);
      end

      for (int i = 0; i < DIGITS; i++) begin
        sel_d[i] = (IdxW'(i) == idx_q);
      end
      seg_d = cur_seg;
      dp_d  = bus.pause && (idx_q == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      seg_q   <= SegBlank;
      dp_q    <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.segments  = seg_q;
  assign bus.dp        = dp_q;
  assign bus.digit_sel = sel_q;
  assign bus.count     = cnt_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_seg7_scan_counter.sv
// Bench for seg7_scan_counter: three instances (4-digit decimal, 4-digit hex, 2-digit
// decimal) share one control set; each is compared every cycle against an arithmetic model.
module tb_seg7_scan_counter;

  localparam int TD = 4;
  localparam int SD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic ena, up_dn, pause, clear, blank_lz;

  seg7_scan_counter_if #(.DIGITS(4)) if_d ();
  seg7_scan_counter_if #(.DIGITS(4)) if_h ();
  seg7_scan_counter_if #(.DIGITS(2)) if_2 ();

  assign if_d.ena = ena;  assign if_d.up_dn = up_dn;  assign if_d.pause = pause;
  assign if_d.clear = clear;  assign if_d.blank_lz = blank_lz;
  assign if_h.ena = ena;  assign if_h.up_dn = up_dn;  assign if_h.pause = pause;
  assign if_h.clear = clear;  assign if_h.blank_lz = blank_lz;
  assign if_2.ena = ena;  assign if_2.up_dn = up_dn;  assign if_2.pause = pause;
  assign if_2.clear = clear;  assign if_2.blank_lz = blank_lz;

  seg7_scan_counter #(.DIGITS(4), .TICK_DIV(TD), .SCAN_DIV(SD), .HEX(0)) dut_d (
    .clk(clk), .rst_n(rst_n), .bus(if_d)
  );
  seg7_scan_counter #(.DIGITS(4), .TICK_DIV(TD), .SCAN_DIV(SD), .HEX(1)) dut_h (
    .clk(clk), .rst_n(rst_n), .bus(if_h)
  );
  seg7_scan_counter #(.DIGITS(2), .TICK_DIV(TD), .SCAN_DIV(SD), .HEX(0)) dut_2 (
    .clk(clk), .rst_n(rst_n), .bus(if_2)
  );

  logic [6:0] seg_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model: count held as a plain integer modulo base**digits; scan position as total
  // enabled cycles; display outputs are those expected right after the edge.
  typedef struct {
    int         pre;
    int         n;
    int         scan;
    logic [15:0] cnt;
    logic [7:0]  sel;
    logic [6:0]  seg;
    logic        dp;
    logic        wrap;
  } mdl_t;

  mdl_t m_d, m_h, m_2;
  int   errs = 0;
  int   checks = 0;
  int   wraps_d, wraps_2;

  function automatic int ipow(int b, int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  function automatic logic [15:0] pack(int n, int d, int b);
    logic [15:0] r = '0;
    for (int i = 0; i < d; i++) r[4*i +: 4] = 4'((n / ipow(b, i)) % b);
    return r;
  endfunction

  function automatic mdl_t mreset();
    mdl_t m;
    m.pre = 0; m.n = 0; m.scan = 0; m.cnt = '0;
    m.sel = '0; m.seg = '0; m.dp = 1'b0; m.wrap = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t mi, int d, int b, logic e, logic up, logic ps,
                                 logic cl, logic blz);
    mdl_t m = mi;
    int modv, idx, hi;
    modv = ipow(b, d);
    m.wrap = 1'b0;
    if (!e) begin
      m.sel = '0; m.seg = '0; m.dp = 1'b0;
      return m;
    end
    idx = (m.scan / SD) % d;
    hi = m.n / ipow(b, idx);
    m.sel = 8'(1 << idx);
    m.seg = (blz && idx > 0 && hi == 0) ? 7'h00 : seg_ref[hi % b];
    m.dp = ps && (idx == 0);
    m.scan++;
    if (cl) begin
      m.pre = 0; m.n = 0;
    end else if (!ps) begin
      m.pre++;
      if (m.pre == TD) begin
        m.pre = 0;
        if (up) begin
          m.n = (m.n + 1) % modv;
          m.wrap = (m.n == 0);
        end else begin
          m.wrap = (m.n == 0);
          m.n = (m.n + modv - 1) % modv;
        end
      end
    end
    m.cnt = pack(m.n, d, b);
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    m_d = mstep(m_d, 4, 10, ena, up_dn, pause, clear, blank_lz);
    m_h = mstep(m_h, 4, 16, ena, up_dn, pause, clear, blank_lz);
    m_2 = mstep(m_2, 2, 10, ena, up_dn, pause, clear, blank_lz);
    #1;
    wraps_d += int'(if_d.wrap);
    wraps_2 += int'(if_2.wrap);
    chk("cycle dut_d", {31'b0, if_d.count, 8'(if_d.digit_sel), if_d.segments, if_d.dp, if_d.wrap},
        {31'b0, m_d.cnt, m_d.sel, m_d.seg, m_d.dp, m_d.wrap});
    chk("cycle dut_h", {31'b0, if_h.count, 8'(if_h.digit_sel), if_h.segments, if_h.dp, if_h.wrap},
        {31'b0, m_h.cnt, m_h.sel, m_h.seg, m_h.dp, m_h.wrap});
    chk("cycle dut_2", {31'b0, 16'(if_2.count), 8'(if_2.digit_sel), if_2.segments, if_2.dp,
        if_2.wrap}, {31'b0, m_2.cnt, m_2.sel, m_2.seg, m_2.dp, m_2.wrap});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    m_d = mreset(); m_h = mreset(); m_2 = mreset();
    #2 rst_n = 1'b1;
    wraps_d = 0; wraps_2 = 0;
  endtask

  function automatic int sel_idx(logic [3:0] s);
    int j = 0;
    for (int i = 0; i < 4; i++) if (s[i]) j = i;
    return j;
  endfunction

  typedef struct {
    logic        e, up, ps, cl;
    int          n;
    logic [15:0] xd, xh;
    logic [7:0]  x2;
    int          wd, w2;
  } vec_t;

  vec_t vt [7];

  initial begin
    logic [6:0] nolz [4];
    logic [6:0] lz [4];
    int j;

    vt[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 40,  16'h0010, 16'h000A, 8'h10, 0, 0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 4,   16'h9999, 16'hFFFF, 8'h99, 1, 1};
    vt[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 8,   16'h9998, 16'hFFFE, 8'h98, 1, 1};
    vt[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 20,  16'h0000, 16'h0000, 8'h00, 0, 0};
    vt[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 40,  16'h0000, 16'h0000, 8'h00, 0, 0};
    vt[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 400, 16'h0100, 16'h0064, 8'h00, 0, 1};
    vt[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 40,  16'h0000, 16'h0000, 8'h00, 0, 0};
    nolz = '{7'h3F, 7'h06, 7'h3F, 7'h3F};
    lz   = '{7'h3F, 7'h06, 7'h00, 7'h00};

    ena = 1'b0; up_dn = 1'b1; pause = 1'b0; clear = 1'b0; blank_lz = 1'b0;
    wraps_d = 0; wraps_2 = 0;

    // Table: each vector runs from reset with fixed controls.
    for (int v = 0; v < 7; v++) begin
      ena = vt[v].e; up_dn = vt[v].up; pause = vt[v].ps; clear = vt[v].cl;
      blank_lz = 1'b0;
      do_reset();
      repeat (vt[v].n) cyc();
      chk($sformatf("vec%0d count dut_d", v), 64'(if_d.count), 64'(vt[v].xd));
      chk($sformatf("vec%0d count dut_h", v), 64'(if_h.count), 64'(vt[v].xh));
      chk($sformatf("vec%0d count dut_2", v), 64'(if_2.count), 64'(vt[v].x2));
      chk($sformatf("vec%0d wraps dut_d", v), 64'(wraps_d), 64'(vt[v].wd));
      chk($sformatf("vec%0d wraps dut_2", v), 64'(wraps_2), 64'(vt[v].w2));
    end

    // First edge after reset release, then scan pattern at 0x0010 with/without blanking.
    ena = 1'b1; up_dn = 1'b1; pause = 1'b0; clear = 1'b0; blank_lz = 1'b0;
    do_reset();
    cyc();
    chk("first digit_sel", 64'(if_d.digit_sel), 64'h1);
    chk("first segments", 64'(if_d.segments), 64'h3F);
    repeat (39) cyc();
    pause = 1'b1;
    cyc();
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("scan onehot", 64'($onehot(if_d.digit_sel)), 64'h1);
      j = sel_idx(if_d.digit_sel);
      chk("scan seg no blank", 64'(if_d.segments), 64'(nolz[j]));
      chk("scan dp", 64'(if_d.dp), 64'(j == 0));
    end
    blank_lz = 1'b1;
    cyc();
    for (int k = 0; k < 8; k++) begin
      cyc();
      j = sel_idx(if_d.digit_sel);
      chk("scan seg blank", 64'(if_d.segments), 64'(lz[j]));
    end
    repeat (4) cyc();
    chk("pause hold count", 64'(if_d.count), 64'h0010);

    // Count 0 with blanking: only digit 0 lit.
    pause = 1'b1; blank_lz = 1'b1;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cyc();
      j = sel_idx(if_d.digit_sel);
      chk("zero blank seg", 64'(if_d.segments), (j == 0) ? 64'h3F : 64'h0);
    end

    // Clear coincident with an up step and with a down wrap.
    pause = 1'b0; blank_lz = 1'b0; up_dn = 1'b1;
    do_reset();
    repeat (3) cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clear vs step count", 64'(if_d.count), 64'h0);
    chk("clear vs step wrap", 64'(if_d.wrap), 64'h0);
    repeat (4) cyc();
    chk("after clear count", 64'(if_d.count), 64'h0001);
    up_dn = 1'b0;
    do_reset();
    repeat (3) cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clear vs wrap count", 64'(if_d.count), 64'h0);
    chk("clear vs wrap wrap", 64'(if_d.wrap), 64'h0);

    // Direction sampled only at the step edge.
    up_dn = 1'b1;
    do_reset();
    repeat (4) cyc();
    repeat (2) cyc();
    up_dn = 1'b0;
    repeat (2) cyc();
    chk("mid dir change", 64'(if_d.count), 64'h0000);

    // Asynchronous reset mid-count.
    up_dn = 1'b1;
    do_reset();
    repeat (45) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("async rst dut_d", {31'b0, if_d.count, 8'(if_d.digit_sel), if_d.segments, if_d.dp,
        if_d.wrap}, 64'h0);
    chk("async rst dut_2", {31'b0, 16'(if_2.count), 8'(if_2.digit_sel), if_2.segments, if_2.dp,
        if_2.wrap}, 64'h0);
    m_d = mreset(); m_h = mreset(); m_2 = mreset();
    #1 rst_n = 1'b1;
    repeat (4) cyc();
    chk("restart count", 64'(if_d.count), 64'h0001);

    // Randomized controls against the model.
    up_dn = 1'b0;
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      ena      = ($urandom_range(0, 19) != 0);
      pause    = ($urandom_range(0, 9) == 0);
      clear    = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 63) == 0) up_dn = ~up_dn;
      if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
